// File: rtl/pulse_stretcher_pkg.sv
// Shared types and helpers for the pulse stretcher.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } ps_state_e;

    // Tick counter width: wide enough for the longer of the two windows.
    function automatic int tcnt_w(input int hold_ticks, input int gap_ticks);
        int m;
        m = (hold_ticks > gap_ticks) ? hold_ticks : gap_ticks;
        return (m + 1 > 2) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/pulse_stretcher_tick_gen.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks, restartable.
module tick_gen #(
    parameter int TICK_DIV = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    // Count 0..TICK_DIV-1; a clear restarts the period so windows are exact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr || tick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/pulse_stretcher.sv
// Stretches single-cycle events into fixed-width high windows separated by
// mandatory low gaps; events arriving while busy are queued (saturating).
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int TICK_DIV   = 100,
    parameter int HOLD_TICKS = 8,
    parameter int GAP_TICKS  = 8,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pulse,
    output logic              o_level,
    output logic              o_busy,
    output logic [PEND_W-1:0] o_pend,
    output logic              o_overflow
);
    localparam int TW = tcnt_w(HOLD_TICKS, GAP_TICKS);
    localparam logic [TW-1:0]     HOLD_LAST = TW'(HOLD_TICKS - 1);
    localparam logic [TW-1:0]     GAP_LAST  = TW'(GAP_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    ps_state_e     state, next;
    logic          tick, clr;
    logic [TW-1:0] tcnt;
    logic          hold_done, gap_done;

    assign hold_done = (state == HOLD) && tick && (tcnt == HOLD_LAST);
    assign gap_done  = (state == GAP)  && tick && (tcnt == GAP_LAST);

    // Any state change (including GAP->HOLD) restarts prescaler and tick count.
    assign clr = (next != state);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .tick (tick)
    );

    // Next-state logic.
    always_comb begin
        next = state;
        case (state)
            IDLE: if (i_pulse) next = HOLD;
            HOLD: if (hold_done) next = GAP;
            GAP:  if (gap_done) next = ((o_pend != '0) || i_pulse) ? HOLD : IDLE;
            default: next = IDLE;
        endcase
    end

    // State register with level/busy registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            o_level <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            state   <= next;
            o_level <= (next == HOLD);
            o_busy  <= (next != IDLE);
        end
    end

    // Ticks elapsed within the current state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tcnt <= '0;
        else if (clr)
            tcnt <= '0;
        else if (tick)
            tcnt <= tcnt + 1'b1;
    end

    // Pending queue: the GAP exit consumes one event (a simultaneous pulse
    // replaces it); otherwise pulses while busy queue up or overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pend     <= '0;
            o_overflow <= 1'b0;
        end else if (state != IDLE) begin
            if (gap_done) begin
                if ((o_pend != '0) && !i_pulse)
                    o_pend <= o_pend - 1'b1;
            end else if (i_pulse) begin
                if (o_pend != PEND_MAX)
                    o_pend <= o_pend + 1'b1;
                else
                    o_overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (TICK_DIV=4, HOLD=3, GAP=2, PEND_W=2).
// k counts clock edges since the test start; k=1 is the edge that sees the
// first pulse. One window = 12 high + 8 low cycles.
module tb_pulse_stretcher;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_pulse = 1'b0;
    logic       o_level, o_busy, o_overflow;
    logic [1:0] o_pend;

    int n_chk = 0;
    int n_err = 0;

    pulse_stretcher #(
        .TICK_DIV(4), .HOLD_TICKS(3), .GAP_TICKS(2), .PEND_W(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_pulse    (i_pulse),
        .o_level    (o_level),
        .o_busy     (o_busy),
        .o_pend     (o_pend),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        i_pulse = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    int wins;
    logic prev;

    initial begin
        // Reset state
        do_reset();
        chk("rst_level", o_level, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_pend", o_pend, 0);
        chk("rst_ovf", o_overflow, 0);

        // Single pulse: high k=1..12, low k=13..20, idle from 21
        for (int k = 1; k <= 25; k++) begin
            i_pulse = (k == 1);
            step();
            chk($sformatf("single_level k=%0d", k), o_level, (k <= 12) ? 1 : 0);
            chk($sformatf("single_busy k=%0d", k), o_busy, (k <= 20) ? 1 : 0);
            chk($sformatf("single_pend k=%0d", k), o_pend, 0);
        end

        // Three consecutive pulses: three windows, busy 60 cycles
        do_reset();
        for (int k = 1; k <= 65; k++) begin
            int ep;
            i_pulse = (k <= 3);
            step();
            ep = (k == 1) ? 0 : (k == 2) ? 1 : (k <= 20) ? 2 : (k <= 40) ? 1 : 0;
            chk($sformatf("three_level k=%0d", k), o_level,
                ((k <= 60) && (((k - 1) % 20) < 12)) ? 1 : 0);
            chk($sformatf("three_busy k=%0d", k), o_busy, (k <= 60) ? 1 : 0);
            chk($sformatf("three_pend k=%0d", k), o_pend, ep);
        end

        // Pulse at k=1 then five during HOLD: saturate at 3, overflow, 4 windows
        do_reset();
        wins = 0;
        prev = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            i_pulse = (k == 1) || (k >= 3 && k <= 7);
            step();
            if (o_level && !prev) wins++;
            prev = o_level;
            if (k == 5)  chk("sat_ovf_k5", o_overflow, 0);
            if (k == 5)  chk("sat_pend_k5", o_pend, 3);
            if (k == 6)  chk("sat_ovf_k6", o_overflow, 1);
            if (k == 7)  chk("sat_pend_k7", o_pend, 3);
            if (k == 21) chk("sat_pend_k21", o_pend, 2);
            if (k == 41) chk("sat_pend_k41", o_pend, 1);
            if (k == 61) chk("sat_pend_k61", o_pend, 0);
            if (k == 80) chk("sat_busy_k80", o_busy, 1);
            if (k == 81) chk("sat_busy_k81", o_busy, 0);
        end
        chk("sat_windows", wins, 4);
        chk("sat_ovf_sticky", o_overflow, 1);

        // Pulse on GAP exit with one queued event
        do_reset();
        for (int k = 1; k <= 62; k++) begin
            i_pulse = (k == 1) || (k == 2) || (k == 21);
            step();
            if (k == 20) chk("exit1_level_k20", o_level, 0);
            if (k == 21) chk("exit1_level_k21", o_level, 1);
            if (k == 21) chk("exit1_pend_k21", o_pend, 1);
            if (k == 40) chk("exit1_pend_k40", o_pend, 1);
            if (k == 41) chk("exit1_pend_k41", o_pend, 0);
            if (k == 41) chk("exit1_level_k41", o_level, 1);
            if (k == 60) chk("exit1_busy_k60", o_busy, 1);
            if (k == 61) chk("exit1_busy_k61", o_busy, 0);
        end

        // Pulse on GAP exit with nothing queued: no IDLE cycle in between
        do_reset();
        for (int k = 1; k <= 42; k++) begin
            i_pulse = (k == 1) || (k == 21);
            step();
            if (k == 20) chk("exit0_busy_k20", o_busy, 1);
            if (k == 21) chk("exit0_busy_k21", o_busy, 1);
            if (k == 21) chk("exit0_level_k21", o_level, 1);
            if (k == 21) chk("exit0_pend_k21", o_pend, 0);
            if (k == 32) chk("exit0_level_k32", o_level, 1);
            if (k == 33) chk("exit0_level_k33", o_level, 0);
            if (k == 41) chk("exit0_busy_k41", o_busy, 0);
        end

        // Asynchronous reset mid-HOLD with overflow set
        do_reset();
        for (int k = 1; k <= 8; k++) begin
            i_pulse = (k <= 6);
            step();
        end
        chk("mid_pre_level", o_level, 1);
        chk("mid_pre_pend", o_pend, 3);
        chk("mid_pre_ovf", o_overflow, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_level", o_level, 0);
        chk("mid_busy", o_busy, 0);
        chk("mid_pend", o_pend, 0);
        chk("mid_ovf", o_overflow, 0);
        step();
        rst = 1'b0;
        step();
        for (int k = 1; k <= 22; k++) begin
            i_pulse = (k == 1);
            step();
            chk($sformatf("post_level k=%0d", k), o_level, (k <= 12) ? 1 : 0);
            chk($sformatf("post_busy k=%0d", k), o_busy, (k <= 20) ? 1 : 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
- Output-side counterpart to the button debouncer. The debouncer turns a noisy level into a single-cycle pulse; this block turns single-cycle event pulses into clean level outputs with a guaranteed minimum width.
- Each accepted event produces one high window of fixed length, followed by a mandatory low gap.
- Events that arrive while an output window or gap is in progress are queued in a saturating pending counter.
- Sits between control logic (for example SPI transaction done/start strobes) and slow observers such as LEDs, external pins or a logic analyzer.

Parameters:
- TICK_DIV, 100: clk cycles per tick. Same prescale as the input debouncer.
- HOLD_TICKS, 8: ticks for which o_level is high per event.
- GAP_TICKS, 8: ticks for which o_level is forced low after each window.
- PEND_W, 3: width of the pending-event counter. Maximum queued events = 2^PEND_W-1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- i_pulse, input, 1: event strobe. Synchronous to clk; any cycle high counts as one event.
- o_level, output, 1: stretched output, registered.
- o_busy, output, 1: high when the FSM is not in IDLE.
- o_pend, output, PEND_W: number of queued events not yet output.
- o_overflow, output, 1: sticky flag. Set when an event is dropped; cleared only by rst.

Behaviour:
- Reset (asynchronous, any time, including mid-HOLD or mid-GAP):
  - State goes to IDLE.
  - o_level=0, o_busy=0, o_pend=0, o_overflow=0.
  - Prescaler and tick counter go to 0.
  - o_level falls immediately.
- Prescaler:
  - Counts 0..TICK_DIV-1 and asserts tick for one cycle at TICK_DIV-1, then wraps.
  - Cleared to 0 on every state entry, so window lengths are exact.
- Tick counter: counts ticks within the current state and is cleared on every state entry.
- State IDLE:
  - o_level=0.
  - i_pulse=1 moves the FSM to HOLD at that clock edge. o_level reads 1 from the following cycle (1-cycle latency).
- State HOLD:
  - o_level=1 for exactly HOLD_TICKS*TICK_DIV clk cycles.
  - At the last tick, moves to GAP.
- State GAP:
  - o_level=0 for exactly GAP_TICKS*TICK_DIV clk cycles.
  - At the last tick:
    - o_pend>0 or i_pulse=1: move to HOLD.
    - Otherwise: move to IDLE.
- Pending counter, per cycle, for a pulse arriving in HOLD or GAP (not at the GAP exit edge):
  - o_pend < max: o_pend+1.
  - o_pend == max: o_pend holds and o_overflow is set.
- Pending counter at the GAP exit edge with o_pend>0:
  - No pulse: o_pend-1.
  - Pulse present: increment and decrement cancel, so o_pend is unchanged and no overflow occurs, even at max.
- Pending counter at the GAP exit edge with o_pend==0 and a pulse present:
  - The pulse is consumed directly and o_pend stays 0.
- Pending counter in IDLE: a pulse never changes o_pend.
- o_busy: o_busy = (state != IDLE), registered together with the state.
- Widths:
  - Prescaler is $clog2(TICK_DIV) bits.
  - Tick counter is $clog2(max(HOLD_TICKS,GAP_TICKS)+1) bits.
  - All comparisons are unsigned.
- Parameter constraints: TICK_DIV ≥ 2, HOLD_TICKS ≥ 1, GAP_TICKS ≥ 1.

Decomposition:
- Package pulse_stretcher_pkg:
  - typedef enum logic [1:0] {IDLE, HOLD, GAP} ps_state_e.
  - Localparam helper for the tick-counter width.
- Sub-module tick_gen:
  - Ports: clk, rst, clr, tick.
  - Parameter TICK_DIV.
  - Reused by the debouncer side later.
- The FSM, pending counter and overflow logic live in the top module.

Test Plan (TICK_DIV=4, HOLD_TICKS=3, GAP_TICKS=2, PEND_W=2):
- Single pulse at cycle 10:
  - o_level high for cycles 11..22 (12 cycles), low for the 8 cycles after.
  - o_busy high for 20 cycles, then 0.
  - o_pend stays 0.
- Three pulses on consecutive cycles from IDLE:
  - First pulse starts HOLD; o_pend reads 1, then 2.
  - Three 12-cycle highs, each separated by an 8-cycle low.
  - o_pend decrements 2→1→0 at the GAP exits.
  - o_busy is continuous for 60 cycles.
- Five pulses during HOLD:
  - o_pend saturates at 3 and o_overflow is set and stays set.
  - Exactly 4 high windows are produced in total.
- Pulse exactly on the GAP-exit edge:
  - With o_pend=1: the next HOLD starts and o_pend stays 1.
  - With o_pend=0: HOLD restarts with no IDLE cycle and o_pend stays 0.
- Reset asserted mid-HOLD (cycle 15 of the single-pulse case):
  - o_level, o_busy, o_pend and o_overflow read 0 immediately.
  - After release, a new pulse gives a full 12-cycle window.
